// File: rtl/ext_irq_ctrl_if.sv
// Bus bundle between the external interrupt controller and its environment.
// The slave modport is the controller view; the master modport is the
// board/core side that drives sources, mask, overrun clear and acknowledge.
interface ext_irq_ctrl_if #(
  parameter int NSRC = 4,
  parameter int IDW  = 2
);
  logic [NSRC-1:0] irq_src;
  logic [NSRC-1:0] irq_mask;
  logic            ovr_clr;
  logic            ExtIAck;
  logic            ExtIRQ;
  logic [IDW-1:0]  irq_id;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] overrun;

  modport slave (
    input  irq_src, irq_mask, ovr_clr, ExtIAck,
    output ExtIRQ, irq_id, pending, overrun
  );

  modport master (
    output irq_src, irq_mask, ovr_clr, ExtIAck,
    input  ExtIRQ, irq_id, pending, overrun
  );
endinterface

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller for the core's ExtIRQ/ExtIAck handshake.
// Raw lines are synchronised, rising edges latch pending bits, and the lowest
// enabled pending source is presented to the core one request at a time.
// After each completed handshake a fixed number of idle cycles is enforced.
module ext_irq_ctrl #(
  parameter int NSRC    = 4,
  parameter int IDW     = 2,
  parameter int HOLDOFF = 2
) (
  input  logic         clk,
  input  logic         reset,
  ext_irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAITL = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LOAD = (HOLDOFF == 0) ? 8'd0 : 8'(HOLDOFF - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NSRC-1:0] r_s1;
  logic [NSRC-1:0] r_s2;
  logic [NSRC-1:0] r_s3;
  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_overrun;
  logic            r_irq;
  logic [IDW-1:0]  r_irq_id;
  logic [7:0]      r_cnt;

  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_eligible;
  logic [NSRC-1:0] w_ovr_set;
  logic [NSRC-1:0] w_pending_nxt;
  logic [NSRC-1:0] w_overrun_nxt;
  logic [IDW-1:0]  w_winner;
  logic            w_any;
  logic            w_irq_nxt;
  logic [IDW-1:0]  w_irq_id_nxt;
  logic [7:0]      w_cnt_nxt;

  // Two-flop synchroniser plus a delayed copy used for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= bus.irq_src;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Clear strobe for the source being acknowledged; only REQ honours the ack.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_clr[i] = (r_state == REQ) && bus.ExtIAck && (r_irq_id == IDW'(i));
    end
  end

  // Pending/overrun update: a fresh edge always wins over the clear.
  always_comb begin
    w_edge        = r_s2 & ~r_s3;
    w_ovr_set     = w_edge & r_pending & ~w_clr;
    w_pending_nxt = (r_pending & ~w_clr) | w_edge;
    w_overrun_nxt = (r_overrun & ~{NSRC{bus.ovr_clr}}) | w_ovr_set;
    w_eligible    = r_pending & bus.irq_mask;
  end

  // Lowest eligible index wins; scanning downward leaves the lowest hit last.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner = IDW'(i);
        w_any    = 1'b1;
      end else begin
        w_any    = w_any;
      end
    end
  end

  // Pending and overrun registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Handshake FSM next-state and registered-output values.
  always_comb begin
    w_state_nxt  = r_state;
    w_irq_nxt    = r_irq;
    w_irq_id_nxt = r_irq_id;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_irq_nxt    = 1'b1;
          w_irq_id_nxt = w_winner;
          w_state_nxt  = REQ;
        end else begin
          w_irq_nxt    = 1'b0;
        end
      end
      REQ: begin
        if (bus.ExtIAck) begin
          w_irq_nxt   = 1'b0;
          w_state_nxt = WAITL;
        end else begin
          w_irq_nxt   = 1'b1;
        end
      end
      WAITL: begin
        if (!bus.ExtIAck) begin
          if (HOLDOFF == 0) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt   = HOLD_LOAD;
            w_state_nxt = HOLD;
          end
        end else begin
          w_state_nxt = WAITL;
        end
      end
      HOLD: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_irq_nxt   = 1'b0;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // FSM state, request outputs and holdoff counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_irq    <= 1'b0;
      r_irq_id <= '0;
      r_cnt    <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_irq    <= w_irq_nxt;
      r_irq_id <= w_irq_id_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.ExtIRQ  = r_irq;
  assign bus.irq_id  = r_irq_id;
  assign bus.pending = r_pending;
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl (NSRC=4, HOLDOFF=2).
// Expected request ids are queued when stimulus is applied and compared when
// the controller raises ExtIRQ; directed checks cover latency, masking,
// overrun, held acknowledge and asynchronous reset.
module tb_ext_irq_ctrl;

  logic clk;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  logic [1:0] sb_q[$];
  logic prev_irq = 1'b0;

  ext_irq_ctrl_if #(.NSRC(4), .IDW(2)) bus_if ();

  ext_irq_ctrl #(.NSRC(4), .IDW(2), .HOLDOFF(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] bits);
    bus_if.irq_src = bus_if.irq_src | bits;
    step();
    bus_if.irq_src = bus_if.irq_src & ~bits;
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (!bus_if.ExtIRQ && n < 20) begin
      step();
      n++;
    end
    check(tag, {31'd0, bus_if.ExtIRQ}, 32'd1);
  endtask

  task automatic ack1();
    bus_if.ExtIAck = 1'b1;
    step();
    bus_if.ExtIAck = 1'b0;
  endtask

  task automatic drain();
    repeat (6) step();
  endtask

  // Scoreboard: each new request must match the oldest queued expected id.
  always @(negedge clk) begin
    logic [1:0] e;
    if (bus_if.ExtIRQ && !prev_irq) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", sb_q.size(), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("sb_id", {30'd0, bus_if.irq_id}, {30'd0, e});
      end
    end
    prev_irq <= bus_if.ExtIRQ;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_req;
    reset = 1'b0;
    bus_if.irq_src  = 4'h0;
    bus_if.irq_mask = 4'h0;
    bus_if.ovr_clr  = 1'b0;
    bus_if.ExtIAck  = 1'b0;
    #12;
    check("rst_irq",     {31'd0, bus_if.ExtIRQ},  32'd0);
    check("rst_id",      {30'd0, bus_if.irq_id},  32'd0);
    check("rst_pending", {28'd0, bus_if.pending}, 32'd0);
    check("rst_overrun", {28'd0, bus_if.overrun}, 32'd0);
    step();
    reset = 1'b1;
    bus_if.irq_mask = 4'hF;
    step();
    step();

    // 1: single source, latency and 1-cycle ack
    sb_q.push_back(2'd2);
    pulse(4'b0100);
    step();
    check("t1_irq_k1", {31'd0, bus_if.ExtIRQ}, 32'd0);
    step();
    check("t1_pend_k2", {28'd0, bus_if.pending}, 32'h4);
    check("t1_irq_k2", {31'd0, bus_if.ExtIRQ}, 32'd0);
    step();
    check("t1_irq_k3", {31'd0, bus_if.ExtIRQ}, 32'd1);
    check("t1_id_k3", {30'd0, bus_if.irq_id}, 32'd2);
    ack1();
    check("t1_pend_ack", {28'd0, bus_if.pending}, 32'h0);
    check("t1_irq_ack", {31'd0, bus_if.ExtIRQ}, 32'd0);
    drain();

    // 2: simultaneous edges, priority and back-to-back spacing
    sb_q.push_back(2'd1);
    sb_q.push_back(2'd3);
    pulse(4'b1010);
    wait_irq("t2_req1");
    check("t2_id1", {30'd0, bus_if.irq_id}, 32'd1);
    ack1();
    check("t2_gap0", {31'd0, bus_if.ExtIRQ}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_gap", {31'd0, bus_if.ExtIRQ}, 32'd0);
    end
    step();
    check("t2_req2", {31'd0, bus_if.ExtIRQ}, 32'd1);
    check("t2_id2", {30'd0, bus_if.irq_id}, 32'd3);
    ack1();
    drain();

    // 3: masked source stays pending until enabled
    bus_if.irq_mask = 4'b1110;
    pulse(4'b0001);
    repeat (4) step();
    check("t3_pend", {28'd0, bus_if.pending}, 32'h1);
    check("t3_masked", {31'd0, bus_if.ExtIRQ}, 32'd0);
    sb_q.push_back(2'd0);
    bus_if.irq_mask = 4'hF;
    step();
    check("t3_unmask_irq", {31'd0, bus_if.ExtIRQ}, 32'd1);
    check("t3_unmask_id", {30'd0, bus_if.irq_id}, 32'd0);
    ack1();
    drain();

    // 4: overrun, ovr_clr, and an edge coinciding with the ack cycle
    sb_q.push_back(2'd1);
    pulse(4'b0010);
    step();
    pulse(4'b0010);
    repeat (3) step();
    check("t4_overrun", {28'd0, bus_if.overrun}, 32'h2);
    check("t4_pend", {28'd0, bus_if.pending}, 32'h2);
    bus_if.ovr_clr = 1'b1;
    step();
    bus_if.ovr_clr = 1'b0;
    check("t4_ovr_clr", {28'd0, bus_if.overrun}, 32'h0);
    pulse(4'b0010);
    step();
    sb_q.push_back(2'd1);
    ack1();
    check("t4_pend_keep", {28'd0, bus_if.pending}, 32'h2);
    check("t4_no_ovr", {28'd0, bus_if.overrun}, 32'h0);
    check("t4_irq_ack", {31'd0, bus_if.ExtIRQ}, 32'd0);
    wait_irq("t4_rereq");
    ack1();
    drain();

    // 5: held acknowledge clears once and delays the next request
    sb_q.push_back(2'd2);
    sb_q.push_back(2'd3);
    pulse(4'b1100);
    wait_irq("t5_req1");
    bus_if.ExtIAck = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_held_irq", {31'd0, bus_if.ExtIRQ}, 32'd0);
      check("t5_held_pend", {28'd0, bus_if.pending}, 32'h8);
    end
    bus_if.ExtIAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_gap", {31'd0, bus_if.ExtIRQ}, 32'd0);
    end
    step();
    check("t5_req2", {31'd0, bus_if.ExtIRQ}, 32'd1);
    check("t5_id2", {30'd0, bus_if.irq_id}, 32'd3);
    ack1();
    drain();

    // 6: asynchronous reset during a request
    sb_q.push_back(2'd0);
    pulse(4'b1001);
    wait_irq("t6_req");
    #3;
    reset = 1'b0;
    #1;
    check("t6_irq", {31'd0, bus_if.ExtIRQ}, 32'd0);
    check("t6_pend", {28'd0, bus_if.pending}, 32'h0);
    check("t6_ovr", {28'd0, bus_if.overrun}, 32'h0);
    sb_q.delete();
    #3;
    reset = 1'b1;
    n_req = 0;
    repeat (10) begin
      step();
      if (bus_if.ExtIRQ) n_req++;
    end
    check("t6_quiet", n_req, 32'd0);
    sb_q.push_back(2'd1);
    pulse(4'b0010);
    wait_irq("t6_newreq");
    ack1();
    drain();

    check("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
